// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Multiplexed N-digit 7-segment display driver with per-digit decimal
//   points, leading-zero suppression, PWM brightness, anti-ghosting dead
//   time and tear-free frame latching.
//
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous, active-high reset
//   enable       0 = display off, scan held at its start
//   value        4*DIGITS hex digits, value[3:0] is digit 0 (rightmost)
//   dp           per-digit decimal point, dp[i] belongs to digit i
//   blank_lz     1 = suppress leading zeros
//   brightness   PWM duty level, 0 dimmest, all-ones full
//   seg          segments, seg[0]=a .. seg[6]=g (registered)
//   dp_out       decimal point segment (registered)
//   anode        digit selects, anode[i] drives digit i (registered)
//   frame_start  one-cycle pulse when the digit 0 slot begins
module seven_seg_scanner #(
  parameter int DIGITS           = 2,
  parameter int PRESCALE_BITS    = 12,
  parameter int BRIGHT_BITS      = 3,
  parameter int DEAD_CYCLES      = 2,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int ANODE_ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [4*DIGITS-1:0]      value,
  input  logic [DIGITS-1:0]        dp,
  input  logic                     blank_lz,
  input  logic [BRIGHT_BITS-1:0]   brightness,
  output logic [6:0]               seg,
  output logic                     dp_out,
  output logic [DIGITS-1:0]        anode,
  output logic                     frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF    = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic [PRESCALE_BITS-1:0] cnt_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [4*DIGITS-1:0]      val_reg;
  logic [DIGITS-1:0]        dp_reg;
  logic                     blz_reg;

  logic                     latch_now;
  logic [4*DIGITS-1:0]      cur_val;
  logic [DIGITS-1:0]        cur_dp;
  logic                     cur_blz;
  logic [DIGITS-1:0]        digit_nz;
  logic [DIGITS-1:0]        upper_zero;
  logic [3:0]               digit;
  logic                     digit_dp;
  logic                     digit_upper_zero;
  logic [DIGITS-1:0]        onehot;
  logic [6:0]               pattern;
  logic [BRIGHT_BITS-1:0]   sub;
  logic                     lit;
  logic                     blank;

  assign latch_now = enable && (cnt_reg == '0) && (idx_reg == '0);

  // In the latch cycle the digit 0 outputs are produced from the inputs
  // directly, so the first slot of a frame already shows the new data.
  assign cur_val = latch_now ? value    : val_reg;
  assign cur_dp  = latch_now ? dp       : dp_reg;
  assign cur_blz = latch_now ? blank_lz : blz_reg;

  // upper_zero[i] = every digit j >= i is zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign digit_nz[gi] = |cur_val[4*gi +: 4];
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = ~digit_nz[gi];
      end else begin : g_chain
        assign upper_zero[gi] = ~digit_nz[gi] & upper_zero[gi+1];
      end
    end
  endgenerate

  always_comb begin
    digit            = 4'h0;
    digit_dp         = 1'b0;
    digit_upper_zero = 1'b0;
    onehot           = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        digit            = cur_val[4*i +: 4];
        digit_dp         = cur_dp[i];
        digit_upper_zero = upper_zero[i];
        onehot[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    pattern = 7'h00;
    case (digit)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
  end

  assign blank = cur_blz && (idx_reg != '0) && digit_upper_zero;
  assign sub   = cnt_reg[PRESCALE_BITS-1 -: BRIGHT_BITS];
  // Dead time at the start of each slot hides the seg/idx transition.
  assign lit   = enable && (cnt_reg >= PRESCALE_BITS'(DEAD_CYCLES)) && (sub <= brightness);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      val_reg     <= '0;
      dp_reg      <= '0;
      blz_reg     <= 1'b0;
      seg         <= SEG_OFF;
      dp_out      <= DP_OFF;
      anode       <= ANODE_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch_now;
      if (enable) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == '1) begin
          idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
        if (latch_now) begin
          val_reg <= value;
          dp_reg  <= dp;
          blz_reg <= blank_lz;
        end
        seg    <= blank ? SEG_OFF : (pattern ^ SEG_OFF);
        dp_out <= digit_dp ^ DP_OFF;
        anode  <= lit ? (onehot ^ ANODE_OFF) : ANODE_OFF;
      end else begin
        cnt_reg <= '0;
        idx_reg <= '0;
        seg     <= SEG_OFF;
        dp_out  <= DP_OFF;
        anode   <= ANODE_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIGITS=4, PRESCALE_BITS=4,
// BRIGHT_BITS=2, DEAD_CYCLES=1, active-low segments, active-high anodes.
// After restart(), step number k (from 0) shows the outputs produced by
// cnt = k%16 and idx = (k/16)%4.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  anode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Active-low patterns of "F", "A", "2", "1" (digits 0..3 of 12AF).
  logic [6:0] walk_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  seven_seg_scanner #(
    .DIGITS(4), .PRESCALE_BITS(4), .BRIGHT_BITS(2), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .ANODE_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .dp(dp),
    .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .dp_out(dp_out),
    .anode(anode), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; value = 16'h0; dp = 4'h0;
    blank_lz = 1'b0; brightness = 2'd3;
    step(); step();
    checks++;
    if (anode !== 4'b0000 || seg !== 7'h7F || dp_out !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: anode=%b seg=%h dp_out=%b fs=%b, required 0000 7f 1 0",
               anode, seg, dp_out, frame_start);
    end
  endtask

  task automatic test_walk();
    logic [3:0] exp_an;
    value = 16'h12AF; dp = 4'h0; blank_lz = 1'b0; brightness = 2'd3;
    restart();
    for (int k = 0; k <= 64; k++) begin
      step();
      exp_an = ((k % 16) >= 1) ? (4'b0001 << ((k / 16) % 4)) : 4'b0000;
      checks++;
      if (anode !== exp_an) begin
        errors++;
        $display("FAIL walk_anode k=%0d: got %b, required %b", k, anode, exp_an);
      end
      checks++;
      if (frame_start !== ((k % 64) == 0)) begin
        errors++;
        $display("FAIL walk_frame_start k=%0d: got %b, required %b", k, frame_start, (k % 64) == 0);
      end
      if ((k % 16) == 1) begin
        checks++;
        if (seg !== walk_seg[(k / 16) % 4] || dp_out !== 1'b1) begin
          errors++;
          $display("FAIL walk_seg k=%0d: got seg=%h dp=%b, required seg=%h dp=1",
                   k, seg, dp_out, walk_seg[(k / 16) % 4]);
        end
      end
    end
  endtask

  task automatic test_brightness();
    logic [3:0] exp_an;
    int lim;
    for (int b = 0; b < 2; b++) begin
      brightness = 2'(b);
      lim = (b == 0) ? 3 : 7;
      restart();
      for (int k = 0; k < 32; k++) begin
        step();
        exp_an = ((k % 16) >= 1 && (k % 16) <= lim) ? (4'b0001 << (k / 16)) : 4'b0000;
        checks++;
        if (anode !== exp_an) begin
          errors++;
          $display("FAIL brightness%0d_anode k=%0d: got %b, required %b", b, k, anode, exp_an);
        end
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_blank_lz();
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    for (int p = 0; p < 2; p++) begin
      blank_lz = 1'b1;
      if (p == 0) begin
        value = 16'h0030; dp = 4'b1000;
        exp_seg = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b0};
      end else begin
        value = 16'h0000; dp = 4'b0000;
        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
      end
      restart();
      for (int k = 0; k < 64; k++) begin
        step();
        if ((k % 16) == 1) begin
          checks++;
          if (seg !== exp_seg[k / 16] || dp_out !== exp_dp[k / 16]) begin
            errors++;
            $display("FAIL blank_lz p=%0d digit=%0d: got seg=%h dp=%b, required seg=%h dp=%b",
                     p, k / 16, seg, dp_out, exp_seg[k / 16], exp_dp[k / 16]);
          end
        end
      end
    end
    blank_lz = 1'b0; dp = 4'h0;
  endtask

  task automatic test_tear_free();
    value = 16'h1111;
    restart();
    for (int k = 0; k <= 65; k++) begin
      step();
      if (k == 33 || k == 49) begin
        checks++;
        if (seg !== 7'h79) begin
          errors++;
          $display("FAIL tear_old k=%0d: got %h, required 79", k, seg);
        end
      end
      if (k == 33) value = 16'h2222;
      if (k == 64) begin
        checks++;
        if (frame_start !== 1'b1 || seg !== 7'h24) begin
          errors++;
          $display("FAIL tear_new_frame: got fs=%b seg=%h, required fs=1 seg=24", frame_start, seg);
        end
      end
      if (k == 65) begin
        checks++;
        if (anode !== 4'b0001 || seg !== 7'h24) begin
          errors++;
          $display("FAIL tear_new_digit0: got anode=%b seg=%h, required 0001 24", anode, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    value = 16'h12AF;
    restart();
    for (int k = 0; k <= 40; k++) step();
    checks++;
    if (anode !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_pre: got anode=%b, required 0100", anode);
    end
    reset = 1'b1;
    step();
    checks++;
    if (anode !== 4'b0000 || seg !== 7'h7F || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_off: got anode=%b seg=%h fs=%b, required 0000 7f 0", anode, seg, frame_start);
    end
    reset = 1'b0;
    step();
    checks++;
    if (frame_start !== 1'b1 || anode !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_restart: got fs=%b anode=%b, required 1 0000", frame_start, anode);
    end
    step();
    checks++;
    if (anode !== 4'b0001 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: got anode=%b fs=%b, required 0001 0", anode, frame_start);
    end
  endtask

  task automatic test_enable_drop();
    value = 16'h12AF;
    restart();
    for (int k = 0; k < 20; k++) step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (anode !== 4'b0000 || seg !== 7'h7F || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL enable_off k=%0d: got anode=%b seg=%h fs=%b, required 0000 7f 0",
                 k, anode, seg, frame_start);
      end
    end
    value = 16'h0005;
    enable = 1'b1;
    step();
    checks++;
    if (frame_start !== 1'b1 || anode !== 4'b0000 || seg !== 7'h12) begin
      errors++;
      $display("FAIL enable_relatch: got fs=%b anode=%b seg=%h, required 1 0000 12",
               frame_start, anode, seg);
    end
    step();
    checks++;
    if (anode !== 4'b0001 || seg !== 7'h12) begin
      errors++;
      $display("FAIL enable_restart: got anode=%b seg=%h, required 0001 12", anode, seg);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_brightness();
    test_blank_lz();
    test_tear_free();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised N-digit multiplexed 7-segment display driver. It replaces the fixed two-digit nibble-decode, display-mux and clock-divider chain with one block. Added capabilities: per-digit decimal points, leading-zero suppression, PWM brightness, anti-ghosting dead time and tear-free frame latching. It sits between the user logic (switches, counters) and the board's `seg`/`anode` pins.

Parameters:
- DIGITS, 2, number of digits scanned; range 1..8.
- PRESCALE_BITS, 12, width of the slot counter; one digit slot lasts 2^PRESCALE_BITS clk cycles.
- BRIGHT_BITS, 3, width of the brightness input; must satisfy BRIGHT_BITS <= PRESCALE_BITS.
- DEAD_CYCLES, 2, clocks at the start of each slot during which all anodes are inactive; must be < 2^(PRESCALE_BITS-BRIGHT_BITS).
- SEG_ACTIVE_LOW, 1, 1 means a lit segment or DP drives 0.
- ANODE_ACTIVE_LOW, 0, 1 means a selected anode drives 0.

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = display off, with the scan held at its start.
- value  in  4*DIGITS  hex digits; value[3:0] is digit 0 (rightmost, least significant).
- dp  in  DIGITS  decimal point per digit; dp[i] belongs to digit i.
- blank_lz  in  1  1 = suppress leading zeros.
- brightness  in  BRIGHT_BITS  duty level; 0 is dimmest, all-ones is full.
- seg  out  7  segments; seg[0]=a through seg[6]=g.
- dp_out  out  1  decimal point segment.
- anode  out  DIGITS  digit selects; anode[i] drives digit i.
- frame_start  out  1  one-cycle pulse when the digit 0 slot begins.

Behaviour:
- Reset is synchronous and active-high; it is sampled on clk rising edges only.
  - Slot counter `cnt`, digit index `idx` and latched value/dp are all cleared to 0.
  - `seg` and `dp_out` go to the unlit level; `anode` goes all inactive; `frame_start` goes to 0.
  - Reset asserted mid-frame takes effect at the next edge. The scan then restarts at digit 0 on the first enabled cycle after reset deasserts.
- Scan sequence:
  - `cnt` increments every cycle while enable=1.
  - When `cnt` wraps from all-ones to 0, `idx` advances: 0 → 1 → … → DIGITS-1 → 0.
  - With DIGITS=1, `idx` stays at 0.
- Frame latch:
  - In the cycle where cnt=0 and idx=0 (enabled), `value`, `dp` and `blank_lz` are captured into internal registers.
  - All display data for the frame comes from these registers. Input changes mid-frame are not visible until the next frame.
- `frame_start`: registered pulse, asserted in the cycle after the latch cycle, high for exactly one clk.
- Decode: standard hex 0–F with active-high pattern abcdefg.
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 (bit0=a).
  - The pattern is inverted on output when SEG_ACTIVE_LOW=1.
- Leading-zero suppression (latched blank_lz=1):
  - Digit i is blanked if every latched digit j ≥ i is zero and i ≠ 0. Digit 0 is never blanked.
  - A blanked digit shows no segments, but its DP still follows its latched dp bit.
- Anode gating. With `sub` = cnt[PRESCALE_BITS-1 -: BRIGHT_BITS], anode[idx] is active iff all of:
  - enable=1;
  - cnt ≥ DEAD_CYCLES;
  - sub ≤ brightness.
  All other anodes are always inactive, so at most one anode is active at any time.
- Output timing:
  - `seg`, `dp_out` and `anode` are registered, with 1-cycle latency from the `cnt`/`idx` state that produced them.
  - `seg` and `dp_out` change only in cycles where all anodes are inactive, which the dead time guarantees.
- enable=0:
  - `cnt` and `idx` are held at 0; anodes go inactive on the next edge; `seg` and `dp_out` go to the unlit level.
  - On the cycle where enable returns to 1, the block latches and starts a fresh frame.
- Duty per digit: (brightness+1)/2^BRIGHT_BITS of the slot, minus the dead time.

Test Plan (DIGITS=4, PRESCALE_BITS=4, BRIGHT_BITS=2, DEAD_CYCLES=1, SEG_ACTIVE_LOW=1, ANODE_ACTIVE_LOW=0):
- Reset then enable=1, value=16'h12AF, dp=0, brightness=3 →
  - anode walks 0001, 0010, 0100, 1000 in 16-cycle slots, each active for 15 cycles;
  - seg reads ~71 ("F"), then ~77 ("A"), then ~5B ("2"), then ~06 ("1");
  - frame_start pulses every 64 cycles.
- brightness=0 →
  - each anode is active only at cnt=1..3, i.e. 3 of 16 cycles;
  - with brightness=1, active at cnt=1..7.
- value=16'h0030, blank_lz=1, dp=4'b1000 →
  - digits 3 and 2 show unlit segments, but digit 3 has dp_out lit (0);
  - digit 1 shows "3" (~4F); digit 0 shows "0" (~3F);
  - value=0 shows only digit 0 as "0".
- value changes from 16'h1111 to 16'h2222 during digit 2's slot → remaining slots still show "1"; "2" appears only after the next frame_start.
- Assert reset mid-slot while digit 2 is active →
  - next edge: anode=0000 and seg=7F (all off);
  - after release: the first active anode is 0001, and frame_start fires.
- enable dropped for 10 cycles mid-frame → anodes 0000 throughout; on re-enable the scan restarts at digit 0 with a new latch and frame_start.
